// File: rtl/lcd_write_sequencer.sv
// ============================================================================
// Module  : lcd_write_sequencer
// Purpose : Turns CPU LCD-register request toggles into timed HD44780 writes.
//           Optional power-on init sequence enabled by defining LCD_INIT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_write_sequencer #(
   parameter int T_SETUP   = 2,
   parameter int T_PULSE   = 25,
   parameter int T_HOLD    = 2,
   parameter int T_EXEC    = 2000,
   parameter int T_CLEAR   = 80000,
   parameter int T_POWERUP = 750000,
   parameter int CNT_W     = 20
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_io_lcd,
   output logic        o_lcd_on,
   output logic        o_lcd_en,
   output logic        o_lcd_rs,
   output logic        o_lcd_rw,
   output logic [7:0]  o_lcd_data,
   output logic        o_busy,
   output logic        o_ack
);

   localparam logic [2:0] c_st_idle      = 3'd0;
   localparam logic [2:0] c_st_setup     = 3'd1;
   localparam logic [2:0] c_st_pulse     = 3'd2;
   localparam logic [2:0] c_st_hold      = 3'd3;
   localparam logic [2:0] c_st_wait      = 3'd4;
   localparam logic [2:0] c_st_init_wait = 3'd5;

   localparam logic [CNT_W-1:0] c_setup_m1   = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] c_pulse_m1   = CNT_W'(T_PULSE - 1);
   localparam logic [CNT_W-1:0] c_hold_m1    = CNT_W'(T_HOLD - 1);
   localparam logic [CNT_W-1:0] c_exec_m1    = CNT_W'(T_EXEC - 1);
   localparam logic [CNT_W-1:0] c_clear_m1   = CNT_W'(T_CLEAR - 1);
   localparam logic [CNT_W-1:0] c_powerup_m1 = CNT_W'(T_POWERUP - 1);
   localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);

   logic [2:0]       r_state;
   logic [2:0]       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_en;
   logic             r_rs;
   logic [7:0]       r_data;
   logic             r_busy;
   logic             r_ack;
   logic             r_seen;
   logic             r_on;
   logic             w_pending;
   logic             w_cnt_zero;
   logic             w_is_clear;
   logic             w_more_init;
   logic             w_unused_bits;

   assign w_pending     = (i_io_lcd[30] != r_seen);
   assign w_cnt_zero    = (r_cnt == '0);
   // Clear (0x01) and return-home (0x02/0x03) need the long execution wait
   assign w_is_clear    = !r_rs && (r_data[7:2] == 6'd0) && (r_data != 8'd0);
   assign w_unused_bits = &{i_io_lcd[29:10], i_io_lcd[8]};

`ifdef LCD_INIT_EN
   logic       r_init_act;
   logic [2:0] r_init_idx;

   function automatic logic [7:0] init_cmd(input logic [2:0] idx);
      case (idx)
         3'd0, 3'd1, 3'd2: init_cmd = 8'h38;
         3'd3:             init_cmd = 8'h0C;
         3'd4:             init_cmd = 8'h01;
         default:          init_cmd = 8'h06;
      endcase
   endfunction

   assign w_more_init = r_init_act && (r_init_idx != 3'd5);
`else
   assign w_more_init = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         c_st_idle: begin
            if (w_pending) begin
               w_state_nxt = c_st_setup;
               w_cnt_nxt   = c_setup_m1;
            end
         end
         c_st_setup: begin
            if (w_cnt_zero) begin
               w_state_nxt = c_st_pulse;
               w_cnt_nxt   = c_pulse_m1;
            end else begin
               w_cnt_nxt = r_cnt - c_one;
            end
         end
         c_st_pulse: begin
            if (w_cnt_zero) begin
               w_state_nxt = c_st_hold;
               w_cnt_nxt   = c_hold_m1;
            end else begin
               w_cnt_nxt = r_cnt - c_one;
            end
         end
         c_st_hold: begin
            if (w_cnt_zero) begin
               w_state_nxt = c_st_wait;
               w_cnt_nxt   = w_is_clear ? c_clear_m1 : c_exec_m1;
            end else begin
               w_cnt_nxt = r_cnt - c_one;
            end
         end
         c_st_wait: begin
            if (w_cnt_zero) begin
               // Init commands chain straight into the next write so busy never drops
               w_state_nxt = w_more_init ? c_st_setup : c_st_idle;
               w_cnt_nxt   = w_more_init ? c_setup_m1 : '0;
            end else begin
               w_cnt_nxt = r_cnt - c_one;
            end
         end
`ifdef LCD_INIT_EN
         c_st_init_wait: begin
            // Counts up so the cleared reset counter is the start of the power-on wait
            if (r_cnt == c_powerup_m1) begin
               w_state_nxt = c_st_setup;
               w_cnt_nxt   = c_setup_m1;
            end else begin
               w_cnt_nxt = r_cnt + c_one;
            end
         end
`endif
         default: begin
            w_state_nxt = c_st_idle;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
`ifdef LCD_INIT_EN
         r_state    <= c_st_init_wait;
         r_init_act <= 1'b1;
         r_init_idx <= 3'd0;
`else
         r_state    <= c_st_idle;
`endif
         r_cnt      <= '0;
         r_en       <= 1'b0;
         r_rs       <= 1'b0;
         r_data     <= 8'd0;
         r_busy     <= 1'b0;
         r_ack      <= 1'b0;
         r_seen     <= 1'b0;
         r_on       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_en    <= (w_state_nxt == c_st_pulse);
         r_busy  <= (w_state_nxt != c_st_idle);
         r_on    <= i_io_lcd[31];
         if (r_state == c_st_idle && w_pending) begin
            r_rs   <= i_io_lcd[9];
            r_data <= i_io_lcd[7:0];
            r_seen <= i_io_lcd[30];
         end
`ifdef LCD_INIT_EN
         if (r_state == c_st_init_wait && w_state_nxt == c_st_setup) begin
            r_rs   <= 1'b0;
            r_data <= init_cmd(3'd0);
         end
         if (r_state == c_st_wait && w_cnt_zero && r_init_act) begin
            if (w_more_init) begin
               r_init_idx <= r_init_idx + 3'd1;
               r_rs       <= 1'b0;
               r_data     <= init_cmd(r_init_idx + 3'd1);
            end else begin
               r_init_act <= 1'b0;
            end
         end
         if (r_state == c_st_wait && w_state_nxt == c_st_idle && !r_init_act) begin
            r_ack <= r_seen;
         end
`else
         if (r_state == c_st_wait && w_state_nxt == c_st_idle) begin
            r_ack <= r_seen;
         end
`endif
      end
   end

   assign o_lcd_on   = r_on;
   assign o_lcd_en   = r_en;
   assign o_lcd_rs   = r_rs;
   assign o_lcd_rw   = 1'b0;
   assign o_lcd_data = r_data;
   assign o_busy     = r_busy;
   assign o_ack      = r_ack;

endmodule

`default_nettype wire
